// File: rtl/ldpc_codeword_packer_pkg.sv
// Shared LDPC constants: default sizes, derived field widths and the packer FSM encodings.
package ldpc_codeword_packer_pkg;

    localparam int DEFAULT_MAX_BLOCK_SIZE = 64;
    localparam int DEFAULT_MAX_COLS       = 24;
    localparam int DEFAULT_IN_WIDTH       = 8;

    localparam int WIDTH_BLOCK_LEN = $clog2(DEFAULT_MAX_BLOCK_SIZE + 1);
    localparam int WIDTH_COLS      = $clog2(DEFAULT_MAX_COLS + 1);
    localparam int WIDTH_BITCNT    = $clog2(DEFAULT_MAX_BLOCK_SIZE * DEFAULT_MAX_COLS + DEFAULT_IN_WIDTH + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FILL     = 3'd1;
    localparam logic [2:0] ST_WAIT_DEC = 3'd2;
    localparam logic [2:0] ST_START    = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_SEND     = 3'd5;

    // Index width for a table of 'depth' entries, never narrower than one bit.
    function automatic int indexWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ldpc_codeword_packer_if.sv
// Bundles configuration, input stream and decoder-side signals of the codeword packer.
interface ldpc_codeword_packer_if
    import ldpc_codeword_packer_pkg::*;
#(
    parameter int MAX_BLOCK_SIZE = DEFAULT_MAX_BLOCK_SIZE,
    parameter int MAX_COLS       = DEFAULT_MAX_COLS,
    parameter int IN_WIDTH       = DEFAULT_IN_WIDTH
);

    logic                                  cfg_load;
    logic [$clog2(MAX_BLOCK_SIZE+1)-1:0]   cfg_block_size;
    logic [$clog2(MAX_COLS+1)-1:0]         cfg_cols;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [IN_WIDTH-1:0]                   in_data;
    logic                                  dec_done;
    logic                                  start_input;
    logic [MAX_BLOCK_SIZE-1:0]             data_in;
    logic                                  frame_sent;

    modport slave (
        input  cfg_load, cfg_block_size, cfg_cols, in_valid, in_data, dec_done,
        output in_ready, start_input, data_in, frame_sent
    );

    modport master (
        output cfg_load, cfg_block_size, cfg_cols, in_valid, in_data, dec_done,
        input  in_ready, start_input, data_in, frame_sent
    );

endinterface

// File: rtl/ldpc_codeword_packer.sv
// Collects a serial hard-decision stream into left-aligned lifting-size columns and
// replays the whole codeword to the decoder as one burst of MAX_COLS words.
module ldpc_codeword_packer
    import ldpc_codeword_packer_pkg::*;
#(
    parameter int MAX_BLOCK_SIZE = DEFAULT_MAX_BLOCK_SIZE,
    parameter int MAX_COLS       = DEFAULT_MAX_COLS,
    parameter int IN_WIDTH       = DEFAULT_IN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ldpc_codeword_packer_if.slave bus
);

    localparam int BLK_W = $clog2(MAX_BLOCK_SIZE + 1);
    localparam int COL_W = $clog2(MAX_COLS + 1);
    localparam int CNT_W = $clog2(MAX_BLOCK_SIZE * MAX_COLS + IN_WIDTH + 1);
    localparam int IDX_W = indexWidth(MAX_BLOCK_SIZE);
    localparam int SEL_W = indexWidth(MAX_COLS);

    logic [2:0]       state_q, state_d;
    logic [BLK_W-1:0] blockSize_q, blockSize_d;
    logic [COL_W-1:0] cols_q, cols_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic [COL_W-1:0] colCnt_q, colCnt_d;
    logic [BLK_W-1:0] posCnt_q, posCnt_d;
    logic [SEL_W-1:0] wordCnt_q, wordCnt_d;
    logic             decBusy_q, decBusy_d;
    logic             frameSent_q, frameSent_d;

    logic [MAX_BLOCK_SIZE-1:0] buffer_q [MAX_COLS];

    logic             accept;
    logic             bufClear;
    logic             sendWord;
    logic [IN_WIDTH-1:0] wrEn;
    logic [SEL_W-1:0] wrSel [IN_WIDTH];
    logic [IDX_W-1:0] wrIdx [IN_WIDTH];

    int unsigned fillBit;
    int unsigned fillCol;
    int unsigned fillPos;
    int unsigned fillIdx;
    int unsigned totalBits;

    assign accept = (state_q == ST_FILL) && bus.in_valid;

    // Walk the beat bit by bit with running column/position counters instead of dividing by B;
    // bits past C*B are dropped and any index outside the buffer is suppressed.
    always_comb begin
        totalBits = 32'(cols_q) * 32'(blockSize_q);
        fillBit   = 32'(bitCnt_q);
        fillCol   = 32'(colCnt_q);
        fillPos   = 32'(posCnt_q);
        fillIdx   = 0;
        wrEn      = '0;
        for (int j = 0; j < IN_WIDTH; j++) begin
            fillIdx  = MAX_BLOCK_SIZE - 32'(blockSize_q) + fillPos;
            wrSel[j] = SEL_W'(fillCol);
            wrIdx[j] = IDX_W'(fillIdx);
            if (fillBit < totalBits) begin
                wrEn[j] = accept && (fillCol < MAX_COLS) && (fillIdx < MAX_BLOCK_SIZE);
                fillBit = fillBit + 1;
                fillPos = fillPos + 1;
                if (fillPos >= 32'(blockSize_q)) begin
                    fillPos = 0;
                    fillCol = fillCol + 1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        blockSize_d = blockSize_q;
        cols_d      = cols_q;
        bitCnt_d    = bitCnt_q;
        colCnt_d    = colCnt_q;
        posCnt_d    = posCnt_q;
        wordCnt_d   = wordCnt_q;
        frameSent_d = 1'b0;
        bufClear    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_load) begin
                    blockSize_d = bus.cfg_block_size;
                    cols_d      = bus.cfg_cols;
                    bufClear    = 1'b1;
                    bitCnt_d    = '0;
                    colCnt_d    = '0;
                    posCnt_d    = '0;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    bitCnt_d = CNT_W'(fillBit);
                    colCnt_d = COL_W'(fillCol);
                    posCnt_d = BLK_W'(fillPos);
                    if (fillBit >= totalBits) begin
                        state_d = ST_WAIT_DEC;
                    end
                end
            end
            ST_WAIT_DEC: begin
                // A dec_done arriving this cycle already frees the decoder.
                if (!(decBusy_q && !bus.dec_done)) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                wordCnt_d = '0;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (wordCnt_q == SEL_W'(MAX_COLS - 1)) begin
                    frameSent_d = 1'b1;
                    bufClear    = 1'b1;
                    bitCnt_d    = '0;
                    colCnt_d    = '0;
                    posCnt_d    = '0;
                    wordCnt_d   = '0;
                    state_d     = ST_FILL;
                end else begin
                    wordCnt_d = wordCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Start wins over a simultaneous dec_done so a new codeword is never mistaken as finished.
    always_comb begin
        decBusy_d = decBusy_q;
        if (state_q == ST_START) begin
            decBusy_d = 1'b1;
        end else if (bus.dec_done) begin
            decBusy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            blockSize_q <= '0;
            cols_q      <= '0;
            bitCnt_q    <= '0;
            colCnt_q    <= '0;
            posCnt_q    <= '0;
            wordCnt_q   <= '0;
            decBusy_q   <= 1'b0;
            frameSent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blockSize_q <= blockSize_d;
            cols_q      <= cols_d;
            bitCnt_q    <= bitCnt_d;
            colCnt_q    <= colCnt_d;
            posCnt_q    <= posCnt_d;
            wordCnt_q   <= wordCnt_d;
            decBusy_q   <= decBusy_d;
            frameSent_q <= frameSent_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < MAX_COLS; c++) begin
                buffer_q[c] <= '0;
            end
        end else if (bufClear) begin
            for (int c = 0; c < MAX_COLS; c++) begin
                buffer_q[c] <= '0;
            end
        end else begin
            for (int j = 0; j < IN_WIDTH; j++) begin
                if (wrEn[j]) begin
                    buffer_q[wrSel[j]][wrIdx[j]] <= bus.in_data[j];
                end
            end
        end
    end

    // Columns beyond the configured count go out as zero padding.
    assign sendWord = (state_q == ST_SEND) && (32'(wordCnt_q) < 32'(cols_q)) &&
                      (32'(wordCnt_q) < MAX_COLS);

    assign bus.in_ready    = (state_q == ST_FILL);
    assign bus.start_input = (state_q == ST_START);
    assign bus.frame_sent  = frameSent_q;
    assign bus.data_in     = sendWord ? buffer_q[wordCnt_q] : '0;

endmodule
